// File: rtl/mvu_if.sv
// mvu_if: host-side bus of the matrix-vector unit (memory load ports,
// configuration, start/busy/done handshake and output read port).
interface mvu_if #(
  parameter int N   = 8,
  parameter int M   = 8,
  parameter int DW  = 8,
  parameter int SCW = 16,
  parameter int BW  = 32,
  parameter int OW  = 16
) ();
  localparam int AW = $clog2(M * N);
  localparam int NW = $clog2(N);
  localparam int RW = $clog2(M);

  logic                  wmem_we;
  logic [AW-1:0]         wmem_addr;
  logic signed [DW-1:0]  wmem_wdata;
  logic                  dmem_we;
  logic [NW-1:0]         dmem_addr;
  logic signed [DW-1:0]  dmem_wdata;
  logic [RW:0]           cfg_rows;
  logic signed [SCW-1:0] cfg_scaler;
  logic signed [BW-1:0]  cfg_bias;
  logic [4:0]            cfg_shift;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [RW-1:0]         omem_raddr;
  logic signed [OW-1:0]  omem_rdata;

  modport master (
    output wmem_we, wmem_addr, wmem_wdata, dmem_we, dmem_addr, dmem_wdata,
    output cfg_rows, cfg_scaler, cfg_bias, cfg_shift, start, omem_raddr,
    input  busy, done, omem_rdata
  );

  modport slave (
    input  wmem_we, wmem_addr, wmem_wdata, dmem_we, dmem_addr, dmem_wdata,
    input  cfg_rows, cfg_scaler, cfg_bias, cfg_shift, start, omem_raddr,
    output busy, done, omem_rdata
  );
endinterface

// File: rtl/mvu_top.sv
// mvu_top: matrix-vector unit computing, per row,
//   y = sat(((W*x) * scaler + bias) >>> shift)
// Build option: define MVU_RELU_EN to replace negative results by zero
// before write-back (timing unchanged).
module mvu_top #(
  parameter int N    = 8,
  parameter int M    = 8,
  parameter int DW   = 8,
  parameter int ACCW = 32,
  parameter int SCW  = 16,
  parameter int BW   = 32,
  parameter int OW   = 16
) (
  input  logic clk,
  input  logic rst_n,
  mvu_if.slave bus
);
  localparam int NW = $clog2(N);
  localparam int RW = $clog2(M);
  localparam int PW = 2 * DW;
  localparam int TW = ACCW + SCW;
  localparam logic signed [TW-1:0] SAT_MAX = TW'((32'sd1 <<< (OW - 1)) - 32'sd1);
  localparam logic signed [TW-1:0] SAT_MIN = TW'(-(32'sd1 <<< (OW - 1)));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_SCALE = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_r, next_state_s;

  logic signed [DW-1:0]   wmem_r [M*N];
  logic signed [DW-1:0]   dmem_r [N];
  logic signed [OW-1:0]   omem_r [M];

  logic [RW:0]            rows_r;
  logic signed [SCW-1:0]  scaler_r;
  logic signed [BW-1:0]   bias_r;
  logic [4:0]             shift_r;
  logic [RW-1:0]          row_r;
  logic [NW-1:0]          col_r;
  logic signed [ACCW-1:0] acc_r;
  logic signed [OW-1:0]   res_r;
  logic signed [OW-1:0]   rdata_r;
  logic                   busy_r, done_r;
  logic                   busy_s, done_s;

  logic [RW:0]            rows_clamp_s;
  logic                   last_row_s;
  logic signed [PW-1:0]   w_s, x_s, prod_s;
  logic signed [ACCW-1:0] prod_ext_s;
  logic signed [TW-1:0]   acc_ext_s, scl_ext_s, bias_ext_s, t_s, t_sh_s;
  logic signed [OW-1:0]   sat_s, res_s;

  // Clamp a wide value to the signed output range.
  function automatic logic signed [OW-1:0] sat_fn(input logic signed [TW-1:0] v);
    logic signed [OW-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b0, {(OW-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(OW-1){1'b0}}};
    end else begin
      r = v[OW-1:0];
    end
    return r;
  endfunction

  // Row-count clamp and last-row detection.
  always_comb begin
    if (bus.cfg_rows > (RW+1)'(M)) begin
      rows_clamp_s = (RW+1)'(M);
    end else begin
      rows_clamp_s = bus.cfg_rows;
    end
    last_row_s = (({1'b0, row_r} + (RW+1)'(1)) >= rows_r);
  end

  // MAC product and scale/bias/shift/saturate datapath.
  always_comb begin
    w_s        = PW'(wmem_r[{row_r, col_r}]);
    x_s        = PW'(dmem_r[col_r]);
    prod_s     = w_s * x_s;
    prod_ext_s = {{(ACCW-PW){prod_s[PW-1]}}, prod_s};
    acc_ext_s  = {{SCW{acc_r[ACCW-1]}}, acc_r};
    scl_ext_s  = {{ACCW{scaler_r[SCW-1]}}, scaler_r};
    bias_ext_s = {{(TW-BW){bias_r[BW-1]}}, bias_r};
    t_s        = acc_ext_s * scl_ext_s + bias_ext_s;
    t_sh_s     = t_s >>> shift_r;
    sat_s      = sat_fn(t_sh_s);
`ifdef MVU_RELU_EN
    if (sat_s[OW-1]) begin
      res_s = {OW{1'b0}};
    end else begin
      res_s = sat_s;
    end
`else
    res_s = sat_s;
`endif
  end

  // FSM next-state logic; start is only honoured in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          if (rows_clamp_s == (RW+1)'(0)) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_MAC;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_MAC: begin
        if (col_r == NW'(N - 1)) begin
          next_state_s = S_SCALE;
        end else begin
          next_state_s = S_MAC;
        end
      end
      S_SCALE: next_state_s = S_WRITE;
      S_WRITE: begin
        if (last_row_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_MAC;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // FSM output decode from the upcoming state, so busy/done can be registered.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (next_state_s)
      S_MAC, S_SCALE, S_WRITE: busy_s = 1'b1;
      S_DONE:                  done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Configuration latch, row/column counters and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_r   <= '0;
      scaler_r <= '0;
      bias_r   <= '0;
      shift_r  <= 5'd0;
      row_r    <= '0;
      col_r    <= '0;
      acc_r    <= '0;
      res_r    <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            rows_r   <= rows_clamp_s;
            scaler_r <= bus.cfg_scaler;
            bias_r   <= bus.cfg_bias;
            shift_r  <= bus.cfg_shift;
            row_r    <= '0;
            col_r    <= '0;
            acc_r    <= '0;
          end
        end
        S_MAC: begin
          acc_r <= acc_r + prod_ext_s;
          col_r <= col_r + NW'(1);
        end
        S_SCALE: res_r <= res_s;
        S_WRITE: begin
          acc_r <= '0;
          col_r <= '0;
          if (!last_row_s) begin
            row_r <= row_r + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory arrays (not reset); host loads are accepted only in IDLE.
  always_ff @(posedge clk) begin
    if (state_r == S_IDLE && bus.wmem_we) begin
      wmem_r[bus.wmem_addr] <= bus.wmem_wdata;
    end
    if (state_r == S_IDLE && bus.dmem_we) begin
      dmem_r[bus.dmem_addr] <= bus.dmem_wdata;
    end
    if (state_r == S_WRITE) begin
      omem_r[row_r] <= res_r;
    end
  end

  // Registered output read port (old data when reading a row being written).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else begin
      rdata_r <= omem_r[bus.omem_raddr];
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.omem_rdata = rdata_r;
endmodule

// File: tb/tb_mvu_top.sv
// tb_mvu_top: directed + randomized bench for mvu_top with a behavioural
// row model (plain integer arithmetic) and an expected output-memory image.
module tb_mvu_top;
  localparam int N = 8;
  localparam int M = 8;

  logic clk;
  logic rst_n;

  mvu_if u_bus ();

  mvu_top u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     w_m [M*N];
  int     x_m [N];
  longint om_m [M];
  int     errs   = 0;
  int     checks = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected row result straight from the arithmetic definition.
  function automatic longint model_row(int r, int sc, int bi, int sh);
    int     acc;
    longint t;
    acc = 0;
    for (int c = 0; c < N; c++) acc += w_m[r*N + c] * x_m[c];
    t = longint'(acc) * longint'(sc) + longint'(bi);
    t = t >>> sh;
    if (t > 32767) t = 32767;
    else if (t < -32768) t = -32768;
`ifdef MVU_RELU_EN
    if (t < 0) t = 0;
`endif
    return t;
  endfunction

  task automatic load_mem();
    for (int i = 0; i < M*N; i++) begin
      u_bus.wmem_we = 1'b1; u_bus.wmem_addr = 6'(i); u_bus.wmem_wdata = 8'(w_m[i]);
      tick();
    end
    u_bus.wmem_we = 1'b0;
    for (int i = 0; i < N; i++) begin
      u_bus.dmem_we = 1'b1; u_bus.dmem_addr = 3'(i); u_bus.dmem_wdata = 8'(x_m[i]);
      tick();
    end
    u_bus.dmem_we = 1'b0;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < M*N; i++) w_m[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < N; i++)   x_m[i] = int'($urandom_range(0, 255)) - 128;
    load_mem();
  endtask

  task automatic set_cfg(input int rows, input int sc, input int bi, input int sh);
    u_bus.cfg_rows   = 4'(rows);
    u_bus.cfg_scaler = 16'(sc);
    u_bus.cfg_bias   = 32'(bi);
    u_bus.cfg_shift  = 5'(sh);
  endtask

  // One complete operation with timing checks; poke injects a start and
  // memory writes while busy, which must have no effect.
  task automatic run(input string tag, input int rows, input int sc, input int bi,
                     input int sh, input bit poke);
    int rc, exp_cyc, done_cyc, done_cnt, busy_cnt;
    logic busy_at_done;
    rc = (rows > M) ? M : rows;
    exp_cyc = rc * (N + 2) + 1;
    set_cfg(rows, sc, bi, sh);
    u_bus.start = 1'b1;
    tick();
    u_bus.start = 1'b0;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_at_done = 1'bx;
    for (int cyc = 1; cyc <= exp_cyc + 4; cyc++) begin
      if (u_bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = u_bus.busy; end
      end
      if (u_bus.busy === 1'b1) busy_cnt++;
      if (poke && cyc == 5) begin
        u_bus.start = 1'b1;
        u_bus.wmem_we = 1'b1; u_bus.wmem_addr = 6'($urandom_range(0, 63));
        u_bus.wmem_wdata = 8'($urandom);
        u_bus.dmem_we = 1'b1; u_bus.dmem_addr = 3'($urandom_range(0, 7));
        u_bus.dmem_wdata = 8'($urandom);
      end else begin
        u_bus.start = 1'b0; u_bus.wmem_we = 1'b0; u_bus.dmem_we = 1'b0;
      end
      tick();
    end
    check({tag, "_done_cycle"}, done_cyc, exp_cyc);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_cycles"}, busy_cnt, exp_cyc - 1);
    check({tag, "_busy_at_done"}, {63'd0, busy_at_done}, 0);
    for (int r = 0; r < rc; r++) om_m[r] = model_row(r, sc, bi, sh);
  endtask

  task automatic rd(input string tag, input int r, input longint exp);
    u_bus.omem_raddr = 3'(r);
    tick();
    check(tag, u_bus.omem_rdata, exp);
  endtask

  task automatic readback(input string tag);
    for (int r = 0; r < M; r++) rd($sformatf("%s_row%0d", tag, r), r, om_m[r]);
  endtask

  initial begin
    int sc, bi, sh, rows;
    rst_n = 1'b1;
    u_bus.wmem_we = 1'b0; u_bus.wmem_addr = '0; u_bus.wmem_wdata = '0;
    u_bus.dmem_we = 1'b0; u_bus.dmem_addr = '0; u_bus.dmem_wdata = '0;
    u_bus.start = 1'b0; u_bus.omem_raddr = '0;
    set_cfg(0, 0, 0, 0);
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset_busy", u_bus.busy, 0);
    check("reset_done", u_bus.done, 0);
    check("reset_rdata", u_bus.omem_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Identity weights, x = 1..8 -> omem[i] = i+1.
    for (int i = 0; i < M*N; i++) w_m[i] = ((i / N) == (i % N)) ? 1 : 0;
    for (int i = 0; i < N; i++)   x_m[i] = i + 1;
    load_mem();
    run("ident", 8, 1, 0, 0, 1'b0);
    rd("ident_r0", 0, 1);
    rd("ident_r3", 3, 4);
    rd("ident_r7", 7, 8);
    readback("ident");

    // Scaler and bias: acc=16, 16*3-5 = 43; >>>2 -> 10.
    for (int i = 0; i < M*N; i++) w_m[i] = 1;
    for (int i = 0; i < N; i++)   x_m[i] = 2;
    load_mem();
    run("scl", 2, 3, -5, 0, 1'b0);
    rd("scl_r0", 0, 43);
    rd("scl_r1", 1, 43);
    rd("scl_r2_kept", 2, 3);
    run("scl_sh", 2, 3, -5, 2, 1'b0);
    rd("scl_sh_r0", 0, 10);
    rd("scl_sh_r1", 1, 10);

    // Saturation both ways.
    for (int i = 0; i < M*N; i++) w_m[i] = 127;
    for (int i = 0; i < N; i++)   x_m[i] = 127;
    load_mem();
    run("sat_pos", 1, 1, 0, 0, 1'b0);
    rd("sat_pos_r0", 0, 32767);
    for (int i = 0; i < N; i++)   x_m[i] = -128;
    load_mem();
    run("sat_neg", 1, 1, 0, 0, 1'b0);
`ifdef MVU_RELU_EN
    rd("sat_neg_r0", 0, 0);
`else
    rd("sat_neg_r0", 0, -32768);
`endif

    // Zero weights with negative bias (done at cycle 11).
    for (int i = 0; i < M*N; i++) w_m[i] = 0;
    load_mem();
    run("nbias", 1, 5, -100, 0, 1'b0);
`ifdef MVU_RELU_EN
    rd("nbias_r0", 0, 0);
`else
    rd("nbias_r0", 0, -100);
`endif
    readback("nbias");

    // rows=0 leaves memory untouched; rows=12 clamps to 8.
    run("rows0", 0, 1, 0, 0, 1'b0);
    readback("rows0");
    rand_mem();
    run("rows12", 12, int'($urandom_range(0, 65535)) - 32768,
        int'($urandom_range(0, 2097151)) - 1048576, int'($urandom_range(6, 20)), 1'b0);
    readback("rows12");

    // Second start and memory writes while busy are ignored.
    rand_mem();
    run("poke", 8, int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 2000)) - 1000,
        int'($urandom_range(4, 12)), 1'b1);
    readback("poke");

    // Reset in the middle of row 1 MAC: row 0 already written, no done pulse.
    rand_mem();
    sc = int'($urandom_range(0, 255)) - 128;
    bi = int'($urandom_range(0, 2000)) - 1000;
    sh = int'($urandom_range(2, 10));
    set_cfg(8, sc, bi, sh);
    u_bus.start = 1'b1;
    tick();
    u_bus.start = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", u_bus.busy, 0);
    check("midrst_done", u_bus.done, 0);
    repeat (2) tick();
    check("midrst_done_hold", u_bus.done, 0);
    rst_n = 1'b1;
    tick();
    check("midrst_done_after", u_bus.done, 0);
    om_m[0] = model_row(0, sc, bi, sh);
    readback("midrst");
    run("after_rst", 8, 1, 0, 0, 1'b0);
    readback("after_rst");

    // Randomized operations.
    for (int k = 0; k < 3; k++) begin
      rand_mem();
      rows = int'($urandom_range(1, 8));
      sc = int'($urandom_range(0, 65535)) - 32768;
      bi = int'($urandom_range(0, 2097151)) - 1048576;
      sh = int'($urandom_range(0, 31));
      run($sformatf("rnd%0d", k), rows, sc, bi, sh, 1'b0);
      readback($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mvu_top.md
Name: mvu_top

Overview:
- Compact matrix-vector unit (MVU) top: computes y = sat(((W·x) * scaler + bias) >>> shift) for up to M rows of N signed elements.
- Host side (testbench or controller, through the MVU bus interface) loads weight and data memories, programs scaler/bias/shift/rows, then pulses start.
- Results are written to an internal output memory readable by the host; completion is flagged with a one-cycle done pulse.

Parameters:
- N, 8, elements per vector (power of 2)
- M, 8, maximum output rows (power of 2)
- DW, 8, signed weight/data element width
- ACCW, 32, signed accumulator width
- SCW, 16, signed scaler width
- BW, 32, signed bias width
- OW, 16, signed output element width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- wmem_we  in  1  weight memory write enable
- wmem_addr  in  log2(M*N)  weight address = row*N + col
- wmem_wdata  in  DW  weight value
- dmem_we  in  1  data memory write enable
- dmem_addr  in  log2(N)  vector element index
- dmem_wdata  in  DW  data value
- cfg_rows  in  log2(M)+1  number of rows to compute
- cfg_scaler  in  SCW  signed scaler
- cfg_bias  in  BW  signed bias
- cfg_shift  in  5  arithmetic right shift amount
- start  in  1  start pulse
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- omem_raddr  in  log2(M)  output read address
- omem_rdata  out  OW  registered output read data (1-cycle latency)

Behaviour:
- Reset: busy=0, done=0, omem_rdata=0, FSM=IDLE, counters=0. Memory contents are not cleared.
- States: IDLE, MAC, SCALE, WRITE, DONE.
- IDLE + start=1: latch all cfg_* inputs, row=0, col=0, acc=0, go to MAC. start is ignored in every other state.
- Row clamping: cfg_rows=0 goes straight to DONE. cfg_rows>M is clamped to M.
- MAC, N cycles per row: acc += sext(W[row][col]) * sext(x[col]), full signed product, accumulate mod 2^ACCW. After col=N-1, go to SCALE.
- SCALE, 1 cycle: t = acc * scaler, full ACCW+SCW bits signed; t += sext(bias); t = t >>> shift (arithmetic); saturate to [-2^(OW-1), 2^(OW-1)-1].
- WRITE, 1 cycle: omem[row] = result; acc=0; col=0. If row+1 < rows: row++, go to MAC; else go to DONE.
- DONE, 1 cycle: done=1, busy=0 next cycle, return to IDLE.
- Latency: start at cycle 0 gives done at cycle rows*(N+2)+1; rows=0 gives done at cycle 1.
- wmem/dmem writes are ignored while busy. They are accepted in IDLE, and the new value is visible to the next start.
- Output reads are allowed at any time: omem_rdata = omem[omem_raddr] on the following cycle. A read of a row being written returns the old value that cycle.
- Rows at or above cfg_rows keep their previous contents.
- Reset mid-operation: FSM returns to IDLE immediately, no done pulse, partial omem writes remain.

Optional Feature:
- Macro MVU_RELU_EN.
- Defined: after saturation, negative results are replaced by 0 before WRITE (ReLU).
- Undefined: the signed saturated value is written unchanged.
- Timing is identical in both builds.

Test Plan:
- Identity W (W[i][i]=1, else 0), x=1..8, scaler=1, bias=0, shift=0, rows=8 -> omem[i]=i+1; done at cycle 81; busy high cycles 1..80.
- Scalar+bias: all W=1, x all 2 (acc=16), scaler=3, bias=-5, shift=0, rows=2 -> omem[0]=omem[1]=43. Same with shift=2 -> 10.
- Saturation: all W=127, x=127 (acc=129032), scaler=1, bias=0 -> 32767. With x=-128 (acc=-130048) -> -32768. With MVU_RELU_EN defined -> 0.
- Negative bias: W=0, bias=-100, scaler=5, rows=1 -> omem[0]=-100 (0 with MVU_RELU_EN). done at cycle 11.
- rows=0 -> done at cycle 1, omem unchanged. rows=12 -> clamped to 8, done at cycle 81.
- Control corners: second start during busy ignored (exactly one done); wmem_we during busy has no effect on results; rst_n low mid-MAC -> busy=0, no done, a subsequent start completes normally.
